// File: rtl/axi_wr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | axi_wr_arbiter: two-requester AXI write arbiter, one burst in flight  (rev 1.0)   |
// | AXI_WR_ARB_FIXED_PRIO_EN defined: M0 always wins contention, else round-robin     |
// +-----------------------------------------------------------------------------------+
module axi_wr_arbiter #(
   parameter int B_TIMEOUT = 255
) (
   input  logic        ACLK_i,
   input  logic        ARESET_i,
   input  logic        M0_REQ_i,
   input  logic [31:0] M0_AWADDR_i,
   input  logic [3:0]  M0_AWID_i,
   input  logic [3:0]  M0_WLEN_i,
   input  logic [31:0] M0_WDATA_i,
   input  logic        M0_WVALID_i,
   output logic        M0_WREADY_o,
   output logic        M0_GNT_o,
   output logic        M0_DONE_o,
   output logic [1:0]  M0_BRESP_o,
   input  logic        M1_REQ_i,
   input  logic [31:0] M1_AWADDR_i,
   input  logic [3:0]  M1_AWID_i,
   input  logic [3:0]  M1_WLEN_i,
   input  logic [31:0] M1_WDATA_i,
   input  logic        M1_WVALID_i,
   output logic        M1_WREADY_o,
   output logic        M1_GNT_o,
   output logic        M1_DONE_o,
   output logic [1:0]  M1_BRESP_o,
   output logic [31:0] AWADDR_o,
   output logic [3:0]  AWID_o,
   output logic        AWVALID_o,
   input  logic        AWREADY_i,
   output logic [31:0] WDATA_o,
   output logic        WVALID_o,
   output logic        WLAST_o,
   input  logic        WREADY_i,
   input  logic        BVALID_i,
   input  logic [1:0]  BRESP_i,
   input  logic [3:0]  BID_i,
   output logic        BREADY_o
);

   localparam int TW = $clog2(B_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            sel_q, sel_d;
   logic [31:0]     addr_q, addr_d;
   logic [3:0]      id_q, id_d;
   logic [3:0]      len_q, len_d;
   logic [3:0]      beat_q, beat_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            done_q, done_d;
   logic [1:0]      bresp0_q, bresp0_d;
   logic [1:0]      bresp1_q, bresp1_d;
   logic            fin;
   logic [1:0]      fin_resp;
   logic            win;
   logic            in_data;

`ifdef AXI_WR_ARB_FIXED_PRIO_EN
   assign win = ~M0_REQ_i;
`else
   logic last_q;

   // Pointer moves at completion so the DONE-cycle arbitration already sees it.
   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) begin
         last_q <= 1'b1;
      end else if (fin) begin
         last_q <= sel_q;
      end
   end

   assign win = (M0_REQ_i && M1_REQ_i) ? ~last_q : M1_REQ_i;
`endif

   assign in_data     = (state_q == S_DATA);
   assign AWVALID_o   = (state_q == S_ADDR);
   assign AWADDR_o    = addr_q;
   assign AWID_o      = id_q;
   assign WVALID_o    = in_data && (sel_q ? M1_WVALID_i : M0_WVALID_i);
   assign WDATA_o     = in_data ? (sel_q ? M1_WDATA_i : M0_WDATA_i) : 32'd0;
   assign WLAST_o     = WVALID_o && (beat_q == len_q);
   assign M0_WREADY_o = in_data && !sel_q && WREADY_i;
   assign M1_WREADY_o = in_data && sel_q && WREADY_i;
   assign BREADY_o    = (state_q == S_RESP);
   assign M0_GNT_o    = ((state_q != S_IDLE) || done_q) && !sel_q;
   assign M1_GNT_o    = ((state_q != S_IDLE) || done_q) && sel_q;
   assign M0_DONE_o   = done_q && !sel_q;
   assign M1_DONE_o   = done_q && sel_q;
   assign M0_BRESP_o  = bresp0_q;
   assign M1_BRESP_o  = bresp1_q;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      addr_d   = addr_q;
      id_d     = id_q;
      len_d    = len_q;
      beat_d   = beat_q;
      tmo_d    = tmo_q;
      done_d   = 1'b0;
      bresp0_d = bresp0_q;
      bresp1_d = bresp1_q;
      fin      = 1'b0;
      fin_resp = 2'b00;
      case (state_q)
         S_IDLE: begin
            if (M0_REQ_i || M1_REQ_i) begin
               sel_d   = win;
               addr_d  = win ? M1_AWADDR_i : M0_AWADDR_i;
               id_d    = win ? M1_AWID_i : M0_AWID_i;
               len_d   = win ? M1_WLEN_i : M0_WLEN_i;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (AWREADY_i) begin
               beat_d  = 4'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (WVALID_o && WREADY_i) begin
               if (beat_q == len_q) begin
                  tmo_d   = '0;
                  state_d = S_RESP;
               end else begin
                  beat_d = beat_q + 4'd1;
               end
            end
         end
         S_RESP: begin
            // A B with a foreign ID is consumed (BREADY high) but otherwise ignored.
            if (BVALID_i && (BID_i == id_q)) begin
               fin      = 1'b1;
               fin_resp = BRESP_i;
            end else if (tmo_q == TW'(B_TIMEOUT - 1)) begin
               fin      = 1'b1;
               fin_resp = 2'b10;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
            if (fin) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
               if (sel_q) bresp1_d = fin_resp;
               else       bresp0_d = fin_resp;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) begin
         state_q  <= S_IDLE;
         sel_q    <= 1'b0;
         addr_q   <= 32'd0;
         id_q     <= 4'd0;
         len_q    <= 4'd0;
         beat_q   <= 4'd0;
         tmo_q    <= '0;
         done_q   <= 1'b0;
         bresp0_q <= 2'b00;
         bresp1_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         addr_q   <= addr_d;
         id_q     <= id_d;
         len_q    <= len_d;
         beat_q   <= beat_d;
         tmo_q    <= tmo_d;
         done_q   <= done_d;
         bresp0_q <= bresp0_d;
         bresp1_q <= bresp1_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------------+
// | tb_axi_wr_arbiter: self-checking bench with a transaction-level reference model   |
// +-----------------------------------------------------------------------------------+
module tb_axi_wr_arbiter;

   localparam int TO = 8;

   logic        ACLK_i, ARESET_i;
   logic        m_req   [2];
   logic [31:0] m_addr  [2];
   logic [3:0]  m_id    [2];
   logic [3:0]  m_len   [2];
   logic [31:0] m_wdata [2];
   logic        m_wvalid[2];
   logic        M0_WREADY_o, M0_GNT_o, M0_DONE_o, M1_WREADY_o, M1_GNT_o, M1_DONE_o;
   logic [1:0]  M0_BRESP_o, M1_BRESP_o;
   logic [31:0] AWADDR_o, WDATA_o;
   logic [3:0]  AWID_o;
   logic        AWVALID_o, AWREADY_i, WVALID_o, WLAST_o, WREADY_i;
   logic        BVALID_i, BREADY_o;
   logic [1:0]  BRESP_i;
   logic [3:0]  BID_i;

   int          errors = 0;
   int          checks = 0;
   int          model_last = 1;
   logic [1:0]  model_b [2];

   axi_wr_arbiter #(.B_TIMEOUT(TO)) dut (
      .ACLK_i(ACLK_i), .ARESET_i(ARESET_i),
      .M0_REQ_i(m_req[0]), .M0_AWADDR_i(m_addr[0]), .M0_AWID_i(m_id[0]), .M0_WLEN_i(m_len[0]),
      .M0_WDATA_i(m_wdata[0]), .M0_WVALID_i(m_wvalid[0]), .M0_WREADY_o(M0_WREADY_o),
      .M0_GNT_o(M0_GNT_o), .M0_DONE_o(M0_DONE_o), .M0_BRESP_o(M0_BRESP_o),
      .M1_REQ_i(m_req[1]), .M1_AWADDR_i(m_addr[1]), .M1_AWID_i(m_id[1]), .M1_WLEN_i(m_len[1]),
      .M1_WDATA_i(m_wdata[1]), .M1_WVALID_i(m_wvalid[1]), .M1_WREADY_o(M1_WREADY_o),
      .M1_GNT_o(M1_GNT_o), .M1_DONE_o(M1_DONE_o), .M1_BRESP_o(M1_BRESP_o),
      .AWADDR_o(AWADDR_o), .AWID_o(AWID_o), .AWVALID_o(AWVALID_o), .AWREADY_i(AWREADY_i),
      .WDATA_o(WDATA_o), .WVALID_o(WVALID_o), .WLAST_o(WLAST_o), .WREADY_i(WREADY_i),
      .BVALID_i(BVALID_i), .BRESP_i(BRESP_i), .BID_i(BID_i), .BREADY_o(BREADY_o)
   );

   initial begin
      ACLK_i = 1'b0;
      forever #5 ACLK_i = ~ACLK_i;
   end

   task automatic tick();
      @(posedge ACLK_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic gnt(input int w);
      return (w == 1) ? M1_GNT_o : M0_GNT_o;
   endfunction
   function automatic logic done(input int w);
      return (w == 1) ? M1_DONE_o : M0_DONE_o;
   endfunction
   function automatic logic wrdy(input int w);
      return (w == 1) ? M1_WREADY_o : M0_WREADY_o;
   endfunction
   function automatic logic [1:0] bresp(input int w);
      return (w == 1) ? M1_BRESP_o : M0_BRESP_o;
   endfunction

   // Arbitration rule: lone requester wins; on contention the one not granted last.
   function automatic int pick(input logic r0, input logic r1);
      if (r0 && r1) begin
`ifdef AXI_WR_ARB_FIXED_PRIO_EN
         return 0;
`else
         return (model_last == 0) ? 1 : 0;
`endif
      end
      return r0 ? 0 : 1;
   endfunction

   task automatic raise(input int n, input logic [31:0] a, input logic [3:0] id, input logic [3:0] len);
      m_addr[n] = a;
      m_id[n]   = id;
      m_len[n]  = len;
      m_req[n]  = 1'b1;
   endtask

   // One complete burst for requester w, starting at the grant edge and returning in the DONE cycle.
   // b_at: RESP cycle with the matching B (>= TO means none, timeout); bad_at: RESP cycle with a foreign BID.
   task automatic serve(input int w, input int aw_wait, input int wmode, input int b_at,
                        input int bad_at, input logic [1:0] resp);
      logic [31:0] data [16];
      int          beat, cyc, o;
      logic        vld, rdy;
      logic [1:0]  exp_b;
      o = 1 - w;
      for (int i = 0; i < 16; i++) data[i] = $urandom;
      tick();
      chk("gnt_at_grant", gnt(w), 1);
      chk("gnt_other_at_grant", gnt(o), 0);
      chk("awvalid", AWVALID_o, 1);
      chk("awaddr", AWADDR_o, m_addr[w]);
      chk("awid", AWID_o, m_id[w]);
      m_req[w] = 1'b0;
      for (int k = 0; k < aw_wait; k++) begin
         tick();
         chk("awvalid_hold", AWVALID_o, 1);
         chk("awaddr_hold", AWADDR_o, m_addr[w]);
      end
      AWREADY_i = 1'b1;
      tick();
      AWREADY_i = 1'b0;
      chk("awvalid_drop", AWVALID_o, 0);
      beat = 0;
      cyc  = 0;
      vld  = 1'b0;
      while (beat <= int'(m_len[w])) begin
         if (cyc == 100) begin
            chk("data_phase_bound", 0, 1);
            break;
         end
         if (!vld) vld = (wmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         rdy = (wmode == 0) ? 1'b1 : (wmode == 1) ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
         m_wdata[w]  = data[beat];
         m_wvalid[w] = vld;
         m_wdata[o]  = $urandom;
         m_wvalid[o] = 1'b1;
         WREADY_i    = rdy;
         #1;
         chk("wvalid", WVALID_o, vld);
         if (vld) chk("wdata", WDATA_o, data[beat]);
         chk("wlast", WLAST_o, vld && (beat == int'(m_len[w])));
         chk("wready_granted", wrdy(w), rdy);
         chk("wready_other", wrdy(o), 0);
         tick();
         if (vld && rdy) begin
            beat++;
            vld = 1'b0;
         end
         cyc++;
      end
      m_wvalid[0] = 1'b0;
      m_wvalid[1] = 1'b0;
      WREADY_i    = 1'b0;
      for (int c = 0; ; c++) begin
         if (c == b_at) begin
            BVALID_i = 1'b1; BID_i = m_id[w]; BRESP_i = resp;
         end else if (c == bad_at) begin
            BVALID_i = 1'b1; BID_i = m_id[w] ^ 4'($urandom_range(1, 15)); BRESP_i = 2'($urandom);
         end else begin
            BVALID_i = 1'b0;
         end
         #1;
         chk("bready", BREADY_o, 1);
         chk("no_early_done", done(w), 0);
         tick();
         if (c == b_at || c == TO - 1) break;
      end
      BVALID_i = 1'b0;
      exp_b = (b_at < TO) ? resp : 2'b10;
      chk("done_pulse", done(w), 1);
      chk("done_other", done(o), 0);
      chk("gnt_in_done", gnt(w), 1);
      chk("bresp", bresp(w), exp_b);
      chk("bresp_other_held", bresp(o), model_b[o]);
      model_b[w] = exp_b;
      model_last = w;
   endtask

   initial begin
      int w;
      ARESET_i = 1'b1;
      AWREADY_i = 1'b0; WREADY_i = 1'b0; BVALID_i = 1'b0; BRESP_i = 2'b00; BID_i = 4'd0;
      for (int n = 0; n < 2; n++) begin
         m_req[n] = 1'b0; m_addr[n] = 32'd0; m_id[n] = 4'd0; m_len[n] = 4'd0;
         m_wdata[n] = 32'd0; m_wvalid[n] = 1'b0; model_b[n] = 2'b00;
      end
      tick();
      tick();
      ARESET_i = 1'b0;
      chk("rst_gnt0", M0_GNT_o, 0);
      chk("rst_gnt1", M1_GNT_o, 0);
      chk("rst_awvalid", AWVALID_o, 0);
      chk("rst_wvalid", WVALID_o, 0);
      chk("rst_wlast", WLAST_o, 0);
      chk("rst_bready", BREADY_o, 0);
      chk("rst_done", {M0_DONE_o, M1_DONE_o}, 0);
      chk("rst_awaddr", AWADDR_o, 0);
      chk("rst_awid", AWID_o, 0);
      chk("rst_bresp", {M0_BRESP_o, M1_BRESP_o}, 0);

      // Basic single-requester burst, everything ready immediately
      raise(0, 32'h1010_1010, 4'd4, 4'd3);
      serve(0, 0, 0, 0, -1, 2'b00);

      // Simultaneous requests, then a repeat contention from the DONE cycle
      raise(0, 32'hA000_0000, 4'd1, 4'd0);
      raise(1, 32'hB000_0000, 4'd2, 4'd0);
      w = pick(1'b1, 1'b1);
      serve(w, 0, 0, 0, -1, 2'b00);
      raise(w, 32'hC000_0000, 4'd3, 4'd0);
      w = pick(1'b1, 1'b1);
      serve(w, 1, 0, 1, -1, 2'b01);
      serve(1 - w, 0, 0, 0, -1, 2'b11);

      // WREADY toggling over a two-beat burst
      raise(0, 32'h0000_2000, 4'd5, 4'd1);
      serve(0, 0, 1, 0, -1, 2'b00);

      // Foreign BID discarded, matching one completes with OKAY-exclusive
      raise(0, 32'h0000_3000, 4'd4, 4'd0);
      serve(0, 0, 0, 1, 0, 2'b01);

      // No B at all: timeout completion
      raise(1, 32'h0000_4000, 4'd9, 4'd2);
      serve(1, 0, 0, TO + 5, -1, 2'b00);

      // Reset in the middle of the data phase
      raise(0, 32'h0000_5000, 4'd6, 4'd7);
      tick();
      m_req[0] = 1'b0;
      AWREADY_i = 1'b1;
      tick();
      AWREADY_i = 1'b0;
      m_wvalid[0] = 1'b1;
      WREADY_i = 1'b1;
      tick();
      tick();
      ARESET_i = 1'b1;
      tick();
      ARESET_i = 1'b0;
      chk("abort_gnt", M0_GNT_o, 0);
      chk("abort_awvalid", AWVALID_o, 0);
      chk("abort_wvalid", WVALID_o, 0);
      chk("abort_wready", M0_WREADY_o, 0);
      chk("abort_bready", BREADY_o, 0);
      chk("abort_bresp", {M0_BRESP_o, M1_BRESP_o}, 0);
      m_wvalid[0] = 1'b0;
      WREADY_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("abort_no_done", {M0_DONE_o, M1_DONE_o}, 0);
         tick();
      end
      model_last = 1;
      model_b[0] = 2'b00;
      model_b[1] = 2'b00;

      // Randomised traffic
      for (int it = 0; it < 24; it++) begin
         int b_at;
         for (int n = 0; n < 2; n++)
            if (!m_req[n] && $urandom_range(0, 1) == 1)
               raise(n, $urandom, 4'($urandom), 4'($urandom_range(0, 15)));
         if (!m_req[0] && !m_req[1])
            raise(0, $urandom, 4'($urandom), 4'($urandom_range(0, 15)));
         w = pick(m_req[0], m_req[1]);
         b_at = $urandom_range(0, 10);
         serve(w, $urandom_range(0, 2), $urandom_range(0, 2), b_at,
               $urandom_range(0, 9), 2'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter: B_TIMEOUT, default 255, cycles in state RESP without a matching B before forced completion.
REQ-003 ACLK_i  input  1  clock; all logic on rising edge.
REQ-004 ARESET_i  input  1  synchronous active-high reset.
REQ-005 Mn_REQ_i  input  1  requester n (n=0,1) requests one write burst; held until Mn_GNT_o.
REQ-006 Mn_AWADDR_i / Mn_AWID_i / Mn_WLEN_i  input  32/4/4  burst address, ID, beats-1; stable while REQ high.
REQ-007 Mn_WDATA_i / Mn_WVALID_i  input  32/1  requester write beat.
REQ-008 Mn_WREADY_o  output  1  beat accepted from requester n.
REQ-009 Mn_GNT_o  output  1  high from grant until Mn_DONE_o cycle inclusive.
REQ-010 Mn_DONE_o / Mn_BRESP_o  output  1/2  one-cycle completion pulse, captured response.
REQ-011 AWADDR_o / AWID_o / AWVALID_o  output  32/4/1; AWREADY_i input 1  AXI write-address channel.
REQ-012 WDATA_o / WVALID_o / WLAST_o  output  32/1/1; WREADY_i input 1  AXI write-data channel.
REQ-013 BVALID_i / BRESP_i / BID_i  input  1/2/4; BREADY_o output 1  AXI write-response channel.

Function
REQ-014 FSM states IDLE, ADDR, DATA, RESP; one burst in flight at a time.
REQ-015 IDLE: any REQ high -> grant per arbitration, latch addr/ID/len into internal registers, assert GNT, next ADDR; no REQ -> stay.
REQ-016 Round-robin: single requester wins; both high -> grant the one not granted last; last-granted pointer updates on DONE.
REQ-017 ADDR: AWVALID_o=1, AWADDR_o/AWID_o = latched values, held stable until AWREADY_i; on AWVALID_o&&AWREADY_i -> DATA, AWVALID_o=0 next cycle.
REQ-018 DATA: WDATA_o/WVALID_o combinationally routed from granted requester; granted Mn_WREADY_o = WREADY_i; ungranted Mn_WREADY_o=0.
REQ-019 4-bit beat counter cleared on entering DATA, +1 per WVALID_o&&WREADY_i; WLAST_o = WVALID_o && (count==latched len).
REQ-020 Last-beat handshake -> RESP; WLEN=0 is a single beat with WLAST_o on it; WLEN=15 gives 16 beats, counter never wraps.
REQ-021 RESP: BREADY_o=1; BVALID_i && BID_i==latched ID -> Mn_BRESP_o<=BRESP_i, Mn_DONE_o pulse, -> IDLE.
REQ-022 RESP: BVALID_i with mismatched BID_i SHALL be accepted and discarded, no state change.
REQ-023 RESP timeout counter: B_TIMEOUT cycles without match -> Mn_BRESP_o<=2'b10, DONE pulse, -> IDLE.
REQ-024 Earliest new grant is the cycle after DONE (IDLE visited at least one cycle).
REQ-025 REQ deassertion after grant ignored; REQ of the other requester waits without loss.
REQ-026 Mn_BRESP_o holds last value until next DONE for that requester.

Reset
REQ-027 ARESET_i high at a clock edge -> state IDLE, all valid/ready/GNT/DONE/WLAST outputs 0, AWADDR_o/AWID_o/BRESP outputs 0, counters 0, last-granted pointer = 1 (M0 wins first contention).
REQ-028 Reset mid-burst aborts immediately; no DONE is issued for the aborted burst.

Configuration
REQ-029 Macro AXI_WR_ARB_FIXED_PRIO_EN defined -> fixed priority, M0 always wins contention, pointer unused; undefined -> round-robin per REQ-016.

Verification
REQ-030 M0 only, addr 0x10101010, ID 4, WLEN 3, AWREADY/WREADY/BVALID immediate, BID 4, BRESP 00 -> AW one handshake, 4 beats, WLAST on 4th, M0_DONE_o pulse, M0_BRESP_o=00.
REQ-031 M0 and M1 request same cycle, both WLEN 0 -> M0 served first, M1 next; repeat with both -> M1 served first on next contention (round-robin).
REQ-032 WREADY_i toggling 1,0,1,0 over WLEN 1 -> WDATA_o stable while stalled, exactly 2 beats, M1_WREADY_o=0 throughout.
REQ-033 BVALID_i with BID 7 then BID 4 (latched 4), BRESP 01 -> first discarded, DONE on second with BRESP 01.
REQ-034 No BVALID_i, B_TIMEOUT=8 -> DONE 8 cycles after entering RESP, BRESP 10; ARESET_i in DATA -> IDLE next cycle, no DONE.
